// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Fetch stage and IF/ID pipeline register for the RV32I pipeline.
//   Owns PC_F, issues instruction-memory requests over a req/ready handshake
//   with variable latency, and presents one instruction per cycle to decode.
//   Hazard stall holds the IF/ID register; flush (PCSrc_E) squashes it and
//   redirects the PC.
//
// Ports
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   stall       in   1   hold PC_F and IF/ID
//   flush       in   1   redirect: squash IF/ID, load PCTarget_E
//   PCTarget_E  in  32   redirect target
//   imem_req    out  1   fetch request
//   imem_addr   out 32   fetch address (always PC_F)
//   imem_ready  in   1   response valid (may coincide with req)
//   imem_rdata  in  32   instruction word
//   instr_D     out 32   IF/ID instruction
//   PC_D        out 32   IF/ID PC
//   PCPlus4_D   out 32   IF/ID PC+4
//   valid_D     out  1   IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] PCTarget_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        valid_D
);

    localparam logic [1:0] ST_FETCH = 2'd0;  // request outstanding at PC_F
    localparam logic [1:0] ST_HOLD  = 2'd1;  // word captured under stall, waiting for decode
    localparam logic [1:0] ST_DRAIN = 2'd2;  // squashed request in flight, response discarded

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        vld_q, vld_d;

    logic [31:0] pc_plus4;
    logic [31:0] buf_pc_plus4;

    assign pc_plus4     = pc_q + 32'd4;
    assign buf_pc_plus4 = buf_pc_q + 32'd4;

    // The address register only advances on a transfer or a redirect, so it
    // is naturally stable while a request is waiting for ready.
    assign imem_req  = (state_q != ST_HOLD);
    assign imem_addr = pc_q;

    assign instr_D   = instr_q;
    assign PC_D      = pcd_q;
    assign PCPlus4_D = pcp4_q;
    assign valid_D   = vld_q;

    // ---- fetch control / IF/ID next state ----
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        vld_d       = vld_q;

        // Flush always bubbles IF/ID, whatever the state; the bubble carries
        // the current PC_F so decode sees a well-defined PC.
        if (flush) begin
            instr_d = NOP_INSTR;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            vld_d   = 1'b0;
        end

        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    if (imem_ready) begin
                        pc_d = PCTarget_E;
                    end else begin
                        // Request cannot be withdrawn; park the target until
                        // the stale response arrives.
                        redirect_d = PCTarget_E;
                        state_d    = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = ST_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        pcp4_d  = pc_plus4;
                        vld_d   = 1'b1;
                    end
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    pcd_d   = pc_q;
                    pcp4_d  = pc_plus4;
                    vld_d   = 1'b0;
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    pc_d    = PCTarget_E;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    instr_d = buf_instr_q;
                    pcd_d   = buf_pc_q;
                    pcp4_d  = buf_pc_plus4;
                    vld_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                if (flush) begin
                    redirect_d = PCTarget_E;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    pcd_d   = pc_q;
                    pcp4_d  = pc_plus4;
                    vld_d   = 1'b0;
                end
                if (imem_ready) begin
                    // A same-cycle flush supersedes the parked target.
                    pc_d    = flush ? PCTarget_E : redirect_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ---- state registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            redirect_q  <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            instr_q     <= NOP_INSTR;
            pcd_q       <= 32'd0;
            pcp4_q      <= 32'd0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pcp4_q      <= pcp4_d;
            vld_q       <= vld_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage plus IF/ID pipeline register for the RV32I pipeline.
- Consumes the hazard unit's stall and flush (PCSrc_E) requests.
- Owns PC_F and drives a req/ready instruction-memory handshake with variable latency.
- Delivers instr_D, PC_D, PCPlus4_D and valid_D to decode, holding or bubbling them as the hazard requests require.

Parameters:
- RESET_PC, 32'h0000_0000, PC_F value on reset.
- NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall: hold PC_F and the IF/ID register.
- flush  in  1  redirect (PCSrc_E): squash IF/ID and load PCTarget_E.
- PCTarget_E  in  32  redirect target, sampled when flush=1.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals PC_F.
- imem_ready  in  1  response valid. May be high in the same cycle as req (zero-wait).
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- instr_D  out  32  IF/ID instruction.
- PC_D  out  32  IF/ID PC.
- PCPlus4_D  out  32  IF/ID PC+4.
- valid_D  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset: asserting rst takes effect immediately, including mid-transaction.
  - State=FETCH, PC_F=RESET_PC, redirect_q=0, buffer cleared.
  - instr_D=NOP_INSTR, PC_D=0, PCPlus4_D=0, valid_D=0.
  - Any pending memory request is abandoned.
  - imem_req=1 in the first cycle after reset releases.
- Handshake:
  - A transfer occurs in a cycle where imem_req=1 and imem_ready=1.
  - imem_addr is held stable while req=1 and no transfer has occurred.
  - req is never dropped before ready.
- Bubble: load IF/ID with {NOP_INSTR, PC_F, PC_F+4, valid=0}.
- Priority for IF/ID updates: flush > stall > normal.
- PC arithmetic: 32-bit modulo; PC_F+4 wraps 0xFFFF_FFFC -> 0x0000_0000.
- FETCH state (req=1):
  - flush & ready: response dropped; PC_F<=PCTarget_E; bubble; stay FETCH.
  - flush & !ready: request in flight. redirect_q<=PCTarget_E; bubble; go DRAIN. PC_F (the address) is unchanged.
  - !flush & ready & !stall: IF/ID<={imem_rdata, PC_F, PC_F+4, 1}; PC_F<=PC_F+4; stay FETCH. Steady state is one instruction per cycle with 1-cycle latency to decode.
  - !flush & ready & stall: buf<={imem_rdata, PC_F}; PC_F<=PC_F+4; IF/ID held; go HOLD.
  - !flush & !ready & !stall: bubble; stay FETCH.
  - !flush & !ready & stall: IF/ID held; stay FETCH.
- HOLD state (req=0, buffered instruction pending):
  - flush: discard buf; PC_F<=PCTarget_E; bubble; go FETCH.
  - !flush & stall: hold everything; stay HOLD.
  - !flush & !stall: IF/ID<={buf.instr, buf.pc, buf.pc+4, 1}; go FETCH.
- DRAIN state (req=1, imem_addr=old PC_F; response will be discarded):
  - A further flush overwrites redirect_q and forces a bubble.
  - Otherwise IF/ID gets a bubble if !stall, and holds if stall.
  - On ready: data dropped; PC_F<=redirect_q (or PCTarget_E if flush is high in the same cycle); go FETCH.
- Invariants:
  - valid_D is never 1 for an instruction fetched before a flush.
  - Exactly one IF/ID load per accepted instruction; none are duplicated or lost across stall.

Test Plan:
- Reset mid-run: rst=1 while in DRAIN at PC_F=0x40 -> instr_D=0x00000013, valid_D=0, PC_F=0 immediately. After release, imem_req=1 and imem_addr=0x0.
- Zero-wait streaming: ready=1 constantly, rdata=addr^0xA5A5_0000 -> PC_D=0,4,8,C on consecutive cycles, one cycle after each address. PCPlus4_D=PC_D+4, valid_D=1.
- Stall with ready=1 at PC_F=0x8 for 2 cycles:
  - imem_req=0 during HOLD.
  - PC_D stays 0x4.
  - Then PC_D=0x8 with the captured word.
  - Next request is 0xC.
  - No duplicate or missing PC.
- Flush during zero-wait: flush=1, PCTarget_E=0x100 -> next cycle valid_D=0, instr_D=NOP, imem_addr=0x100. One cycle later PC_D=0x100, valid_D=1.
- Flush while waiting: ready low for 3 cycles at addr 0x10, flush with target 0x200 in the first of them:
  - imem_addr stays 0x10 until ready.
  - The 0x10 response is dropped.
  - Next request is 0x200.
  - valid_D never shows PC 0x10.
- Stall+flush together in HOLD (buf PC 0x20), PCTarget_E=0x300 -> buffer discarded, bubble, FETCH at 0x300. Also check wrap: PC_F=0xFFFF_FFFC accepted -> next addr 0x0, PCPlus4_D=0x0.
